ssd_scan_ctrl: RTL and testbench



---
 rtl/ssd_pkg.sv | 23 ++
 rtl/ssd_hex_seg.sv | 11 +
 rtl/ssd_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared encodings for the seven-segment scanner: per-digit display modes,
// fixed segment patterns and the hex glyph table ({a..g}, active-low, no dp).
package ssd_pkg;

   typedef enum logic [1:0] {
      MODE_HEX   = 2'b00,
      MODE_BIT   = 2'b01,
      MODE_BLANK = 2'b10,
      MODE_DASH  = 2'b11
   } mode_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hFD;

   // Index 15 first so that HEX_SEG_TBL[n] is the glyph for nibble n.
   localparam logic [15:0][6:0] HEX_SEG_TBL = {
      7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
      7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
      7'b0001101, 7'b0100000, 7'b0100100, 7'b1001100,
      7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
   };

endpackage

// File: rtl/ssd_hex_seg.sv
// Nibble to active-low {a..g} glyph decoder; the decimal point is added by the caller.
module ssd_hex_seg
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG_TBL[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multi-digit seven-segment scanner with frame-coherent shadow registers and blink.
// Define SSD_DIM_EN to add the brightness input (frame-skipping dimmer).
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BLINK_W    = 6
)
(
   input  logic                      dclk_ssd,
   input  logic                      rst_n,
   input  logic [4*NUM_DIGITS-1:0]   digit_val,
   input  logic [2*NUM_DIGITS-1:0]   digit_mode,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   input  logic                      freeze,
`ifdef SSD_DIM_EN
   input  logic [1:0]                brightness,
`endif
   output logic [7:0]                SSD_out,
   output logic [NUM_DIGITS-1:0]     SSD_bit,
   output logic                      frame_start
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LEFT_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [IDX_W-1:0]        idx_r, idx_nxt_s;
   logic [BLINK_W-1:0]      cnt_r, cnt_nxt_s;
   logic [4*NUM_DIGITS-1:0] sh_val_r, val_nxt_s;
   logic [2*NUM_DIGITS-1:0] sh_mode_r, mode_nxt_s;
   logic [NUM_DIGITS-1:0]   sh_dp_r, dp_nxt_s;
   logic [NUM_DIGITS-1:0]   sh_mask_r, mask_nxt_s;
   logic                    fs_edge_s, load_s, lit_s, blink_off_s;
   logic [NUM_DIGITS-1:0]   sel_s;
   logic [3:0]              nib_s, hex_in_s;
   mode_e                   mode_s;
   logic                    dp_s, mask_s;
   logic [6:0]              hex_seg_s;
   logic [7:0]              seg_s;

`ifdef SSD_DIM_EN
   logic [1:0]              sh_bright_r, bright_nxt_s;
`endif

   // Next slot, frame counter and shadow contents; the leftmost slot sees freshly captured inputs.
   always_comb begin
      fs_edge_s = (idx_r == IDX_W'(0));
      if (fs_edge_s) begin
         idx_nxt_s = LEFT_IDX;
         cnt_nxt_s = cnt_r + BLINK_W'(1);
      end else begin
         idx_nxt_s = idx_r - IDX_W'(1);
         cnt_nxt_s = cnt_r;
      end
      load_s     = fs_edge_s & ~freeze;
      val_nxt_s  = load_s ? digit_val  : sh_val_r;
      mode_nxt_s = load_s ? digit_mode : sh_mode_r;
      dp_nxt_s   = load_s ? dp         : sh_dp_r;
      mask_nxt_s = load_s ? blink_mask : sh_mask_r;
`ifdef SSD_DIM_EN
      bright_nxt_s = load_s ? brightness : sh_bright_r;
`endif
   end

   // Select the fields of the digit about to be driven and build its active-low strobe.
   always_comb begin
      sel_s  = {NUM_DIGITS{1'b1}};
      nib_s  = 4'h0;
      mode_s = MODE_HEX;
      dp_s   = 1'b0;
      mask_s = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_nxt_s == IDX_W'(i)) begin
            sel_s[i] = 1'b0;
            nib_s    = val_nxt_s[4*i +: 4];
            mode_s   = mode_e'(mode_nxt_s[2*i +: 2]);
            dp_s     = dp_nxt_s[i];
            mask_s   = mask_nxt_s[i];
         end else begin
            sel_s[i] = 1'b1;
         end
      end
   end

   assign hex_in_s = (mode_s == MODE_BIT) ? {3'b000, nib_s[0]} : nib_s;

   ssd_hex_seg u_hex_seg (
      .nibble (hex_in_s),
      .seg    (hex_seg_s)
   );

   // Compose the segment pattern for the selected digit's mode; dp never lights a blank digit.
   always_comb begin
      seg_s = SEG_BLANK;
      case (mode_s)
         MODE_HEX:   seg_s = {hex_seg_s, ~dp_s};
         MODE_BIT:   seg_s = {hex_seg_s, ~dp_s};
         MODE_BLANK: seg_s = SEG_BLANK;
         MODE_DASH:  seg_s = {SEG_DASH[7:1], ~dp_s};
         default:    seg_s = SEG_BLANK;
      endcase
   end

   assign blink_off_s = cnt_nxt_s[BLINK_W-1] & mask_s;
`ifdef SSD_DIM_EN
   assign lit_s = (cnt_nxt_s[1:0] <= bright_nxt_s);
`else
   assign lit_s = 1'b1;
`endif

   // Scan state, shadows and output pins all advance on the same edge.
   always_ff @(posedge dclk_ssd) begin
      if (!rst_n) begin
         idx_r       <= LEFT_IDX;
         cnt_r       <= {BLINK_W{1'b0}};
         sh_val_r    <= digit_val;
         sh_mode_r   <= digit_mode;
         sh_dp_r     <= dp;
         sh_mask_r   <= blink_mask;
`ifdef SSD_DIM_EN
         sh_bright_r <= brightness;
`endif
         frame_start <= 1'b0;
         SSD_bit     <= {1'b0, {(NUM_DIGITS-1){1'b1}}};
         SSD_out     <= SEG_BLANK;
      end else begin
         idx_r       <= idx_nxt_s;
         cnt_r       <= cnt_nxt_s;
         sh_val_r    <= val_nxt_s;
         sh_mode_r   <= mode_nxt_s;
         sh_dp_r     <= dp_nxt_s;
         sh_mask_r   <= mask_nxt_s;
`ifdef SSD_DIM_EN
         sh_bright_r <= bright_nxt_s;
`endif
         frame_start <= fs_edge_s;
         SSD_bit     <= lit_s ? sel_s : {NUM_DIGITS{1'b1}};
         SSD_out     <= (lit_s && !blink_off_s) ? seg_s : SEG_BLANK;
      end
   end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized and directed bench for ssd_scan_ctrl against a slot/frame level reference model.
module tb_ssd_scan_ctrl;

   localparam int N  = 4;
   localparam int BW = 3;

   logic          dclk_ssd = 1'b0;
   logic          rst_n;
   logic [4*N-1:0] digit_val;
   logic [2*N-1:0] digit_mode;
   logic [N-1:0]  dp;
   logic [N-1:0]  blink_mask;
   logic          freeze;
`ifdef SSD_DIM_EN
   logic [1:0]    brightness;
`endif
   logic [7:0]    SSD_out;
   logic [N-1:0]  SSD_bit;
   logic          frame_start;

   ssd_scan_ctrl #(.NUM_DIGITS(N), .BLINK_W(BW)) dut (
      .dclk_ssd    (dclk_ssd),
      .rst_n       (rst_n),
      .digit_val   (digit_val),
      .digit_mode  (digit_mode),
      .dp          (dp),
      .blink_mask  (blink_mask),
      .freeze      (freeze),
`ifdef SSD_DIM_EN
      .brightness  (brightness),
`endif
      .SSD_out     (SSD_out),
      .SSD_bit     (SSD_bit),
      .frame_start (frame_start)
   );

   always #5 dclk_ssd = ~dclk_ssd;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: which digit is on, frame number, and per-digit captured settings.
   int seg_tbl [16];
   int m_d, m_fc, s_bright;
   int s_val [N];
   int s_mode [N];
   int s_dp [N];
   int s_mask [N];
   logic [7:0]   e_out;
   logic [N-1:0] e_bit;
   logic         e_fs;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic load_shadows();
      for (int i = 0; i < N; i++) begin
         s_val[i]  = int'(digit_val[4*i +: 4]);
         s_mode[i] = int'(digit_mode[2*i +: 2]);
         s_dp[i]   = int'(dp[i]);
         s_mask[i] = int'(blink_mask[i]);
      end
`ifdef SSD_DIM_EN
      s_bright = int'(brightness);
`else
      s_bright = 3;
`endif
   endtask

   function automatic logic [7:0] digit_seg(input int k);
      int code;
      case (s_mode[k])
         0:       code = seg_tbl[s_val[k]];
         1:       code = seg_tbl[s_val[k] % 2];
         3:       code = 'hFD;
         default: code = 'hFF;
      endcase
      if (s_mode[k] != 2 && s_dp[k] != 0) code = code - 1;
      if (((m_fc >> (BW - 1)) % 2 == 1) && s_mask[k] != 0) code = 'hFF;
      return 8'(code);
   endfunction

   // Predict the effect of the coming edge, apply it, then compare just after it.
   task automatic step();
      bit lit;
      if (!rst_n) begin
         m_d  = N - 1;
         m_fc = 0;
         load_shadows();
         e_fs  = 1'b0;
         e_out = 8'hFF;
         for (int i = 0; i < N; i++) e_bit[i] = (i != m_d);
      end else begin
         m_d  = (m_d == 0) ? N - 1 : m_d - 1;
         e_fs = (m_d == N - 1);
         if (e_fs) begin
            m_fc = (m_fc + 1) % (1 << BW);
            if (!freeze) load_shadows();
         end
         lit = ((m_fc % 4) <= s_bright);
         for (int i = 0; i < N; i++) e_bit[i] = !(lit && i == m_d);
         e_out = lit ? digit_seg(m_d) : 8'hFF;
      end
      @(posedge dclk_ssd);
      #1;
      check_val("SSD_bit", 32'(SSD_bit), 32'(e_bit));
      check_val("SSD_out", 32'(SSD_out), 32'(e_out));
      check_val("frame_start", 32'(frame_start), 32'(e_fs));
   endtask

   initial begin
      seg_tbl = '{'h03, 'h9F, 'h25, 'h0D, 'h99, 'h49, 'h41, 'h1B,
                  'h01, 'h09, 'h11, 'hC1, 'h63, 'h85, 'h61, 'h71};
      m_d = N - 1; m_fc = 0; s_bright = 3;
      rst_n      = 1'b0;
      digit_val  = 16'h12AF;
      digit_mode = 8'h00;
      dp         = 4'b0000;
      blink_mask = 4'b0000;
      freeze     = 1'b0;
`ifdef SSD_DIM_EN
      brightness = 2'd3;
`endif
      repeat (2) step();

      // Plain hex scan.
      rst_n = 1'b1;
      repeat (8) step();

      // Inputs changed mid-frame must wait for the next frame start.
      for (int k = 0; k < N && m_d != 1; k++) step();
      digit_val = 16'h0000;
      repeat (6) step();

      // Mixed modes with decimal points.
      digit_mode = 8'b11_10_01_00;
      digit_val  = 16'h0010;
      dp         = 4'b0001;
      repeat (8) step();
      dp = 4'b1111;
      repeat (8) step();

      // Blink on the leftmost digit across two full blink periods (includes counter wrap).
      digit_mode = 8'h00;
      digit_val  = 16'h12AF;
      dp         = 4'b0000;
      blink_mask = 4'b1000;
      repeat (2 * N * (1 << BW)) step();

      // Freeze while inputs toggle, then a reset in the middle of a frame.
      freeze = 1'b1;
      repeat (3 * N) begin
         digit_val = ~digit_val;
         step();
      end
      for (int k = 0; k < N && m_d != 2; k++) step();
      rst_n = 1'b0;
      step();
      rst_n  = 1'b1;
      freeze = 1'b0;
      repeat (8) step();

      // Random traffic with occasional freeze and reset.
      for (int k = 0; k < 1200; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            digit_val  = 16'($urandom);
            digit_mode = 8'($urandom);
            dp         = 4'($urandom);
            blink_mask = 4'($urandom);
`ifdef SSD_DIM_EN
            brightness = 2'($urandom);
`endif
         end
         freeze = ($urandom_range(0, 9) == 0);
         rst_n  = ($urandom_range(0, 99) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
